// File: rtl/truth_table_sweep.sv
// rtl/truth_table_sweep.sv - sequential truth-table sweep over all 2^N minterms
// Emits one (m, vars, s) record per stream transfer and reports the count of true minterms.
module truth_table_sweep #(
  parameter int N = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2**N-1:0]  func,
  input  logic             invert,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     m,
  output logic [N-1:0]     vars,
  output logic             s,
  output logic             busy,
  output logic             done,
  output logic [N:0]       ones
);

  localparam logic [N-1:0] LAST_M = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [2**N-1:0] r_func;
  logic            r_inv;
  logic [N-1:0]    r_m;
  logic [N:0]      r_ones;
  logic            w_s;
  logic            w_xfer;
  logic            w_last;

  // s is decoded only from latched state, so it never sees func or out_ready directly
  assign w_s    = r_func[r_m] ^ r_inv;
  assign w_xfer = (r_state == SWEEP) && out_ready;
  assign w_last = (r_m == LAST_M);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_func  <= '0;
      r_inv   <= 1'b0;
      r_m     <= '0;
      r_ones  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_func <= func;
        r_inv  <= invert;
        r_m    <= '0;
        r_ones <= '0;
      end else if (w_xfer) begin
        r_ones <= r_ones + (N+1)'(w_s);
        if (!w_last) begin
          r_m <= r_m + N'(1);
        end
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = SWEEP;
        end
      end
      SWEEP: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (w_xfer && w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign m    = r_m;
  assign vars = r_m;
  assign s    = w_s;
  assign ones = r_ones;

endmodule

// File: tb/tb_truth_table_sweep.sv
// tb/tb_truth_table_sweep.sv - scoreboard bench for truth_table_sweep at N=2, 3 and 6
// Expected records come from f(m) = func[m] ^ invert evaluated per minterm by the bench.
module tb_truth_table_sweep;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  start_v = 3'b000;
  logic [63:0] func = '0;
  logic        invert = 1'b0;
  logic        out_ready = 1'b1;

  logic       ov2, s2, busy2, done2;
  logic [1:0] m2, v2;
  logic [2:0] ones2;
  logic       ov3, s3, busy3, done3;
  logic [2:0] m3, v3;
  logic [3:0] ones3;
  logic       ov6, s6, busy6, done6;
  logic [5:0] m6, v6;
  logic [6:0] ones6;

  truth_table_sweep #(.N(2)) u_n2 (
    .clk(clk), .reset(reset), .start(start_v[0]), .func(func[3:0]), .invert(invert),
    .out_valid(ov2), .out_ready(out_ready), .m(m2), .vars(v2), .s(s2),
    .busy(busy2), .done(done2), .ones(ones2)
  );
  truth_table_sweep #(.N(3)) u_n3 (
    .clk(clk), .reset(reset), .start(start_v[1]), .func(func[7:0]), .invert(invert),
    .out_valid(ov3), .out_ready(out_ready), .m(m3), .vars(v3), .s(s3),
    .busy(busy3), .done(done3), .ones(ones3)
  );
  truth_table_sweep #(.N(6)) u_n6 (
    .clk(clk), .reset(reset), .start(start_v[2]), .func(func), .invert(invert),
    .out_valid(ov6), .out_ready(out_ready), .m(m6), .vars(v6), .s(s6),
    .busy(busy6), .done(done6), .ones(ones6)
  );

  always #5 clk = ~clk;

  int sel = 0;
  int nn = 2;
  int cyc = 0;
  int t_start = 0;
  int stalls = 0;
  bit pending = 0;
  int n_chk = 0;
  int n_pass = 0;
  int exp_q[$];
  int ones_q[$];

  logic       mvalid, ms, mbusy, mdone;
  logic [5:0] mm, mvars;
  logic [6:0] mones;

  always_comb begin
    mvalid = ov2; ms = s2; mbusy = busy2; mdone = done2;
    mm = {4'b0, m2}; mvars = {4'b0, v2}; mones = {4'b0, ones2};
    if (sel == 1) begin
      mvalid = ov3; ms = s3; mbusy = busy3; mdone = done3;
      mm = {3'b0, m3}; mvars = {3'b0, v3}; mones = {3'b0, ones3};
    end else if (sel == 2) begin
      mvalid = ov6; ms = s6; mbusy = busy6; mdone = done6;
      mm = m6; mvars = v6; mones = ones6;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compares every presented record against the scoreboard head
  always @(negedge clk) begin
    if (!reset) begin
      chk("done_timing", mdone, pending && (cyc == t_start + (1 << nn) + stalls));
      chk("busy", mbusy, pending);
      if (mvalid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          chk("record_m", mm, exp_q[0] >> 1);
          chk("record_vars", mvars, exp_q[0] >> 1);
          chk("record_s", ms, exp_q[0] & 1);
          if (out_ready) void'(exp_q.pop_front());
        end
        if (!out_ready) stalls++;
      end
      if (mdone) begin
        if (ones_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          chk("ones", mones, ones_q.pop_front());
          chk("records_left", exp_q.size(), 0);
        end
        pending = 0;
      end
    end
  end

  task automatic launch(input int s_sel, input int n, input logic [63:0] f, input logic iv);
    int cnt;
    @(posedge clk); #1;
    sel = s_sel; nn = n; func = f; invert = iv; out_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < (1 << n); k++) begin
      int bitv;
      bitv = int'(f[k] ^ iv);
      cnt += bitv;
      exp_q.push_back(k * 2 + bitv);
    end
    ones_q.push_back(cnt);
    start_v = 3'b001 << s_sel;
    @(posedge clk); #1;
    start_v = 3'b000;
    t_start = cyc; stalls = 0; pending = 1;
    func = {$urandom, $urandom};
    invert = 1'($urandom);
  endtask

  task automatic run(input int mode, input bit ign, input bit dstart);
    int stall_n;
    stall_n = 0;
    for (int c = 0; c < 400 && pending; c++) begin
      case (mode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          out_ready = !(mvalid && mm == 6'd2 && stall_n < 3);
          if (!out_ready) stall_n++;
        end
        default: out_ready = 1'b1;
      endcase
      start_v = ((ign && $urandom_range(0, 1) == 1) || (dstart && mdone)) ? (3'b001 << sel) : 3'b000;
      @(posedge clk); #1;
    end
    start_v = 3'b000;
    out_ready = 1'b1;
    if (pending) begin
      chk("sweep_timeout", 0, 1);
      pending = 0; exp_q.delete(); ones_q.delete();
    end
    chk("idle_after_sweep", mbusy, 0);
  endtask

  task automatic sweep(input int s_sel, input int n, input logic [63:0] f, input logic iv,
                       input int mode, input bit ign, input bit dstart);
    launch(s_sel, n, f, iv);
    run(mode, ign, dstart);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid"}, mvalid, 0);
    chk({name, "_m"}, mm, 0);
    chk({name, "_vars"}, mvars, 0);
    chk({name, "_s"}, ms, 0);
    chk({name, "_busy"}, mbusy, 0);
    chk({name, "_done"}, mdone, 0);
    chk({name, "_ones"}, mones, 0);
  endtask

  initial begin
    // Reset with start held high: start must be ignored
    start_v = 3'b111; func = '1;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0; start_v = 3'b000;
    for (int i = 0; i < 10; i++) begin
      chk_zero("reset_idle");
      @(posedge clk); #1;
    end

    sweep(0, 2, 64'b1101, 1'b0, 0, 0, 0);
    sweep(0, 2, 64'b1101, 1'b1, 0, 0, 0);
    sweep(1, 3, 64'hA5, 1'b0, 2, 1, 0);

    launch(0, 2, 64'($urandom), 1'b0);
    for (int c = 0; c < 20 && mm != 6'd2; c++) begin @(posedge clk); #1; end
    chk("mid_reset_reached_m2", mm, 2);
    reset = 1'b1;
    #1;
    pending = 0; exp_q.delete(); ones_q.delete();
    chk_zero("mid_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    sweep(0, 2, 64'b0001, 1'b0, 0, 0, 0);

    sweep(2, 6, '1, 1'b0, 0, 0, 1);
    repeat (3) @(posedge clk);

    for (int r = 0; r < 24; r++) begin
      int rs;
      rs = $urandom_range(0, 2);
      sweep(rs, (rs == 0) ? 2 : (rs == 1) ? 3 : 6, {$urandom, $urandom}, 1'($urandom),
            $urandom_range(0, 1), 1'($urandom), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
